ifetch_ctrl: RTL and testbench

Fetch-front controller that owns the fetch PC register and the instruction-bus request/response handshake. Sits between PC select and the fetch stage. Drives `pc`, `raw_instr` and `instr_valid` into the fetch stage, which forms pc+4 and the decode-register payload. Absorbs variable instruction-bus latency, downstream stalls and mid-flight redirects so the fetch stage only ever sees one clean instruction per accepted PC.

---
 rtl/ifetch_ctrl.sv | 98 +++++++++
 tb/tb_ifetch_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Fetch-front controller: owns the fetch PC and the single-outstanding
// instruction-bus handshake, presenting one clean instruction per accepted PC.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_next_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        ireq_valid_o,
    output logic [31:0] ireq_addr_o,
    input  logic        iresp_addr_ok_i,
    input  logic        iresp_data_ok_i,
    input  logic [31:0] iresp_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] raw_instr_o,
    output logic        instr_valid_o,
    output logic        fetch_busy_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        aligned;
    logic        advance;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        aligned = (pc_q[1:0] == 2'b00);
        advance = flush_i || ((state_q == S_DONE) && !stall_i);
        pc_d    = advance ? pc_next_i : pc_q;

        case (state_q)
            S_REQ: begin
                if (flush_i) begin
                    // A request accepted in the flush cycle still owes a response; drain it.
                    if (aligned && iresp_addr_ok_i && !iresp_data_ok_i)
                        state_d = S_DROP;
                end else if (!aligned) begin
                    buf_d   = '0;
                    state_d = S_DONE;
                end else if (iresp_addr_ok_i && iresp_data_ok_i) begin
                    buf_d   = iresp_data_i;
                    state_d = S_DONE;
                end else if (iresp_addr_ok_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i && iresp_data_ok_i) begin
                    state_d = S_REQ;
                end else if (flush_i) begin
                    state_d = S_DROP;
                end else if (iresp_data_ok_i) begin
                    buf_d   = iresp_data_i;
                    state_d = S_DONE;
                end
            end
            S_DROP: begin
                if (iresp_data_ok_i)
                    state_d = S_REQ;
            end
            S_DONE: begin
                if (flush_i || !stall_i)
                    state_d = S_REQ;
            end
        endcase
    end

    assign ireq_valid_o  = (state_q == S_REQ) && aligned && !reset_i;
    assign ireq_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign raw_instr_o   = buf_q;
    assign instr_valid_o = (state_q == S_DONE);
    assign fetch_busy_o  = !instr_valid_o;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed scenarios plus a randomized run against a transaction-level
// model of the fetch front (outstanding/stale/valid bookkeeping).
module tb_ifetch_ctrl;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        stall, flush;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        addr_ok, data_ok;
    logic [31:0] data;
    logic [31:0] pc, raw_instr;
    logic        instr_valid, fetch_busy;

    int tests = 0;
    int fails = 0;

    ifetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .pc_next_i       (pc_next),
        .stall_i         (stall),
        .flush_i         (flush),
        .ireq_valid_o    (ireq_valid),
        .ireq_addr_o     (ireq_addr),
        .iresp_addr_ok_i (addr_ok),
        .iresp_data_ok_i (data_ok),
        .iresp_data_i    (data),
        .pc_o            (pc),
        .raw_instr_o     (raw_instr),
        .instr_valid_o   (instr_valid),
        .fetch_busy_o    (fetch_busy)
    );

    always #5 clk = ~clk;

    // Response data without acceptance while a request is being presented is a protocol error.
    assert property (@(posedge clk) disable iff (reset) !(data_ok && ireq_valid && !addr_ok))
        else $error("bus protocol violation: data_ok without addr_ok on a live request");

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        reset = 1'b1; flush = 1'b0; stall = 1'b0; pc_next = '0;
        addr_ok = 1'b0; data_ok = 1'b0; data = '0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        hold_reset();
        tests++; if (pc !== RPC) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, RPC); end
        tests++; if (ireq_valid !== 1'b0) begin fails++; $display("FAIL reset_ireq_valid: got %b want 0", ireq_valid); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL reset_fetch_busy: got %b want 1", fetch_busy); end
        tests++; if (raw_instr !== 32'h0) begin fails++; $display("FAIL reset_raw_instr: got %h want 0", raw_instr); end
        // reset in the middle of a transaction returns to a fresh request at RESET_PC
        reset = 1'b0; addr_ok = 1'b1; pc_next = 32'h1234_0000; #1;
        cyc();
        addr_ok = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0; #1;
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== RPC) begin fails++;
            $display("FAIL reset_midflight: got v=%b a=%h want v=1 a=%h", ireq_valid, ireq_addr, RPC); end
    endtask

    task automatic test_best_case();
        hold_reset();
        addr_ok = 1'b1; data_ok = 1'b1; data = 32'h2408_0001; pc_next = 32'hbfc0_0004;
        reset = 1'b0; #1;
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc0_0000) begin fails++;
            $display("FAIL best_req: got v=%b a=%h want v=1 a=bfc00000", ireq_valid, ireq_addr); end
        cyc();
        tests++; if (instr_valid !== 1'b1 || raw_instr !== 32'h2408_0001 || pc !== 32'hbfc0_0000) begin fails++;
            $display("FAIL best_valid: got v=%b i=%h pc=%h want v=1 i=24080001 pc=bfc00000", instr_valid, raw_instr, pc); end
        tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL best_busy: got %b want 0", fetch_busy); end
        addr_ok = 1'b0; data_ok = 1'b0;
        cyc();
        tests++; if (pc !== 32'hbfc0_0004 || instr_valid !== 1'b0 || ireq_addr !== 32'hbfc0_0004) begin fails++;
            $display("FAIL best_advance: got pc=%h v=%b a=%h want pc=bfc00004 v=0", pc, instr_valid, ireq_addr); end
    endtask

    task automatic test_wait_latency();
        hold_reset();
        addr_ok = 1'b1; stall = 1'b1; pc_next = 32'hbfc0_0004;
        reset = 1'b0; #1;
        tests++; if (ireq_valid !== 1'b1) begin fails++; $display("FAIL wait_req: got %b want 1", ireq_valid); end
        for (int c = 2; c <= 4; c++) begin
            cyc();
            addr_ok = 1'b0;
            if (c == 4) begin data_ok = 1'b1; data = 32'h0123_4567; end
            tests++; if (ireq_valid !== 1'b0 || instr_valid !== 1'b0) begin fails++;
                $display("FAIL wait_cycle%0d: got rv=%b iv=%b want 0 0", c, ireq_valid, instr_valid); end
        end
        cyc();
        data_ok = 1'b0;
        tests++; if (instr_valid !== 1'b1 || raw_instr !== 32'h0123_4567) begin fails++;
            $display("FAIL wait_valid: got v=%b i=%h want v=1 i=01234567", instr_valid, raw_instr); end
    endtask

    task automatic test_stall_hold();
        hold_reset();
        addr_ok = 1'b1; data_ok = 1'b1; data = 32'hcafe_f00d; stall = 1'b1; pc_next = 32'hbfc0_0100;
        reset = 1'b0; #1;
        cyc();
        addr_ok = 1'b0; data_ok = 1'b0; data = 32'h5555_aaaa;
        for (int i = 0; i < 4; i++) begin
            tests++; if (instr_valid !== 1'b1 || pc !== RPC || raw_instr !== 32'hcafe_f00d || ireq_valid !== 1'b0) begin fails++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h rv=%b want 1 %h cafef00d 0", i, instr_valid, pc, raw_instr, ireq_valid, RPC); end
            if (i == 3) stall = 1'b0;
            cyc();
        end
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc0_0100) begin fails++;
            $display("FAIL stall_release: got v=%b a=%h want v=1 a=bfc00100", ireq_valid, ireq_addr); end
    endtask

    task automatic test_flush_drop();
        hold_reset();
        addr_ok = 1'b1; stall = 1'b1;
        reset = 1'b0; #1;
        cyc();
        addr_ok = 1'b0; flush = 1'b1; pc_next = 32'h8000_0180;
        cyc();
        flush = 1'b0; pc_next = 32'h8000_0184;
        tests++; if (pc !== 32'h8000_0180 || ireq_valid !== 1'b0 || instr_valid !== 1'b0) begin fails++;
            $display("FAIL drop_enter: got pc=%h rv=%b iv=%b want 80000180 0 0", pc, ireq_valid, instr_valid); end
        cyc();
        tests++; if (ireq_valid !== 1'b0 || instr_valid !== 1'b0) begin fails++;
            $display("FAIL drop_wait: got rv=%b iv=%b want 0 0", ireq_valid, instr_valid); end
        data_ok = 1'b1; data = 32'hdead_beef;
        cyc();
        data_ok = 1'b0;
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_0180 || instr_valid !== 1'b0) begin fails++;
            $display("FAIL drop_rereq: got rv=%b a=%h iv=%b want 1 80000180 0", ireq_valid, ireq_addr, instr_valid); end
        addr_ok = 1'b1; data_ok = 1'b1; data = 32'h1111_2222;
        cyc();
        addr_ok = 1'b0; data_ok = 1'b0;
        tests++; if (instr_valid !== 1'b1 || raw_instr !== 32'h1111_2222 || pc !== 32'h8000_0180) begin fails++;
            $display("FAIL drop_fresh: got v=%b i=%h pc=%h want 1 11112222 80000180", instr_valid, raw_instr, pc); end
    endtask

    task automatic test_flush_over_stall();
        hold_reset();
        addr_ok = 1'b1; data_ok = 1'b1; data = 32'h0000_0042; stall = 1'b1;
        reset = 1'b0; #1;
        cyc();
        addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b1; pc_next = 32'h8000_1000;
        cyc();
        flush = 1'b0;
        tests++; if (pc !== 32'h8000_1000 || instr_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_1000) begin fails++;
            $display("FAIL flush_stall: got pc=%h iv=%b rv=%b a=%h want 80001000 0 1 80001000", pc, instr_valid, ireq_valid, ireq_addr); end
    endtask

    task automatic test_misaligned();
        hold_reset();
        addr_ok = 1'b1; data_ok = 1'b1; data = 32'h7777_7777; pc_next = 32'hbfc0_0002;
        reset = 1'b0; #1;
        cyc();
        addr_ok = 1'b0; data_ok = 1'b0;
        cyc();
        stall = 1'b1; addr_ok = 1'b1;
        tests++; if (pc !== 32'hbfc0_0002 || ireq_valid !== 1'b0) begin fails++;
            $display("FAIL misaligned_noreq: got pc=%h rv=%b want bfc00002 0", pc, ireq_valid); end
        cyc();
        addr_ok = 1'b0;
        tests++; if (instr_valid !== 1'b1 || raw_instr !== 32'h0 || pc !== 32'hbfc0_0002) begin fails++;
            $display("FAIL misaligned_done: got v=%b i=%h pc=%h want 1 0 bfc00002", instr_valid, raw_instr, pc); end
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_instr;
        logic        m_valid, m_outst, m_stale, exp_req, acc, ret, pend;
        hold_reset();
        m_pc = RPC; m_instr = '0; m_valid = 1'b0; m_outst = 1'b0; m_stale = 1'b0; pend = 1'b0;
        reset = 1'b0; #1;
        for (int n = 0; n < 3000; n++) begin
            exp_req = !m_valid && !m_outst && (m_pc[1:0] == 2'b00);
            tests++; if (pc !== m_pc || ireq_addr !== m_pc) begin fails++;
                $display("FAIL rnd_pc@%0d: got pc=%h a=%h want %h", n, pc, ireq_addr, m_pc); end
            tests++; if (ireq_valid !== exp_req || instr_valid !== m_valid || fetch_busy !== !m_valid) begin fails++;
                $display("FAIL rnd_ctl@%0d: got rv=%b iv=%b fb=%b want %b %b %b", n, ireq_valid, instr_valid, fetch_busy, exp_req, m_valid, !m_valid); end
            if (m_valid) begin
                tests++; if (raw_instr !== m_instr) begin fails++;
                    $display("FAIL rnd_instr@%0d: got %h want %h", n, raw_instr, m_instr); end
            end
            flush   = ($urandom_range(7) == 0);
            stall   = ($urandom_range(2) == 0);
            pc_next = $urandom();
            if ($urandom_range(15) != 0) pc_next[1:0] = 2'b00;
            addr_ok = $urandom_range(1);
            data_ok = pend ? ($urandom_range(2) == 0) : (ireq_valid && addr_ok && $urandom_range(3) == 0);
            data    = $urandom();
            acc = exp_req && addr_ok;
            ret = data_ok && (m_outst || acc);
            if (flush) begin
                m_pc = pc_next; m_valid = 1'b0;
                m_outst = (m_outst || acc) && !ret;
                m_stale = m_outst;
            end else if (m_valid) begin
                if (!stall) begin m_pc = pc_next; m_valid = 1'b0; end
            end else if (!m_outst && m_pc[1:0] != 2'b00) begin
                m_valid = 1'b1; m_instr = '0;
            end else if (ret) begin
                if (!m_stale) begin m_valid = 1'b1; m_instr = data; end
                m_outst = 1'b0; m_stale = 1'b0;
            end else if (acc) begin
                m_outst = 1'b1; m_stale = 1'b0;
            end
            pend = (pend || (ireq_valid && addr_ok)) && !data_ok;
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_best_case();
        test_wait_latency();
        test_stall_hold();
        test_flush_drop();
        test_flush_over_stall();
        test_misaligned();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
